// File: rtl/spi_encoder_if.sv
// Register-access side of spi_encoder: request word in, status and read-back data out.
// The controller uses the master modport, the encoder the slave modport.
interface spi_encoder_if #(
   parameter int DATA_SIZE = 24,
   parameter int READ_SIZE = 8
);
   logic                 I_start;
   logic [DATA_SIZE-1:0] I_data;
   logic                 O_busy;
   logic                 O_done;
   logic [READ_SIZE-1:0] O_rdata;

   modport master (
      output I_start,
      output I_data,
      input  O_busy,
      input  O_done,
      input  O_rdata
   );

   modport slave (
      input  I_start,
      input  I_data,
      output O_busy,
      output O_done,
      output O_rdata
   );
endinterface

// File: rtl/spi_encoder.sv
// Mode-0 SPI master serializer (IDLE/SETUP/SHIFT/HOLD/DONE), MSB first, all outputs registered.
// Optional read-back capture on words with MSB=1 is enabled by defining SPI_ENCODER_READBACK_EN.
module spi_encoder #(
   parameter int DATA_SIZE = 24,
   parameter int READ_SIZE = 8,
   parameter int CLK_DIV   = 4
) (
   input  logic         I_clk,
   input  logic         I_reset,
   spi_encoder_if.slave ctl,
   input  logic         I_sdi,
   output logic         O_sclk,
   output logic         O_csb,
   output logic         O_sdo,
   output logic         O_sdo_oe
);
   localparam int BIT_W = $clog2(DATA_SIZE + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 half_q, half_d;   // 0: SCLK-low half of a bit, 1: SCLK-high half
   logic [DATA_SIZE-1:0] shreg_q, shreg_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 sclk_q, sclk_d;
   logic                 csb_q, csb_d;
   logic                 sdo_q, sdo_d;
   logic                 div_end;

   assign div_end = (div_q == LAST_DIV);

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         half_q  <= 1'b0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         half_q  <= half_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      half_d  = half_q;
      shreg_d = shreg_q;
      case (state_q)
         IDLE: begin
            if (ctl.I_start) begin
               state_d = SETUP;
               div_d   = '0;
               bit_d   = '0;
               half_d  = 1'b0;
               shreg_d = ctl.I_data;
            end
         end
         SETUP: begin
            if (div_end) begin
               state_d = SHIFT;
               div_d   = '0;
               half_d  = 1'b0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SHIFT: begin
            if (!div_end) begin
               div_d = div_q + 1'b1;
            end else begin
               div_d = '0;
               if (!half_q) begin
                  half_d = 1'b1;
               end else if (bit_q == LAST_BIT) begin
                  half_d  = 1'b0;
                  state_d = HOLD;
               end else begin
                  // next bit appears on SDO in the first cycle of its low half
                  half_d  = 1'b0;
                  bit_d   = bit_q + 1'b1;
                  shreg_d = shreg_q << 1;
               end
            end
         end
         HOLD: begin
            if (div_end) begin
               state_d = DONE;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so the registered pins line up with state_q.
   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      csb_d  = !(state_d inside {SETUP, SHIFT, HOLD});
      sclk_d = (state_d == SHIFT) && half_d;
      case (state_d)
         SETUP, SHIFT: sdo_d = shreg_d[DATA_SIZE-1];
         HOLD:         sdo_d = sdo_q;
         default:      sdo_d = 1'b0;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sclk_q <= 1'b0;
         csb_q  <= 1'b1;
         sdo_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         sclk_q <= sclk_d;
         csb_q  <= csb_d;
         sdo_q  <= sdo_d;
      end
   end

   assign ctl.O_busy = busy_q;
   assign ctl.O_done = done_q;
   assign O_sclk     = sclk_q;
   assign O_csb      = csb_q;
   assign O_sdo      = sdo_q;

`ifdef SPI_ENCODER_READBACK_EN
   localparam logic [BIT_W-1:0] FIRST_RD_BIT = BIT_W'(DATA_SIZE - READ_SIZE);

   logic                 rd_q, rd_d;
   logic                 oe_q, oe_d;
   logic [READ_SIZE-1:0] cap_q, cap_d;
   logic [READ_SIZE-1:0] rdata_q, rdata_d;
   logic                 sclk_rise;

   // first cycle of a high half is the cycle in which O_sclk rises
   assign sclk_rise = (state_q == SHIFT) && half_q && (div_q == '0);

   always_comb begin
      rd_d = rd_q;
      if (state_q == IDLE && ctl.I_start) begin
         rd_d = ctl.I_data[DATA_SIZE-1];
      end
      oe_d    = !(rd_d && (((state_d == SHIFT) && (bit_d >= FIRST_RD_BIT)) ||
                           (state_d == HOLD) || (state_d == DONE)));
      cap_d   = sclk_rise ? ((cap_q << 1) | READ_SIZE'(I_sdi)) : cap_q;
      rdata_d = ((state_d == DONE) && rd_q) ? cap_q : rdata_q;
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         rd_q    <= 1'b0;
         oe_q    <= 1'b1;
         cap_q   <= '0;
         rdata_q <= '0;
      end else begin
         rd_q    <= rd_d;
         oe_q    <= oe_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
      end
   end

   assign O_sdo_oe    = oe_q;
   assign ctl.O_rdata = rdata_q;
`else
   logic unused_sdi;

   assign unused_sdi  = I_sdi;
   assign O_sdo_oe    = 1'b1;
   assign ctl.O_rdata = '0;
`endif

endmodule

// File: tb/tb_spi_encoder.sv
// Directed bench for spi_encoder at CLK_DIV=2: serialization, busy/CSB timing, start-while-busy,
// mid-transfer reset, back-to-back starts and read-back (expectations follow SPI_ENCODER_READBACK_EN).
module tb_spi_encoder;
   localparam int DATA_SIZE = 24;
   localparam int READ_SIZE = 8;
   localparam int CLK_DIV   = 2;

`ifdef SPI_ENCODER_READBACK_EN
   localparam int                   EXP_OE_LOW      = 35;   // bits 16..23 at 4 cycles each, HOLD 2, DONE 1
   localparam int                   EXP_OE_LOW_RISE = 8;
   localparam logic [READ_SIZE-1:0] EXP_RDATA       = 8'h5A;
`else
   localparam int                   EXP_OE_LOW      = 0;
   localparam int                   EXP_OE_LOW_RISE = 0;
   localparam logic [READ_SIZE-1:0] EXP_RDATA       = 8'h00;
`endif

   logic clk;
   logic reset;
   logic sdi;
   logic sclk;
   logic csb;
   logic sdo;
   logic sdo_oe;

   spi_encoder_if #(.DATA_SIZE(DATA_SIZE), .READ_SIZE(READ_SIZE)) bus ();

   spi_encoder #(
      .DATA_SIZE(DATA_SIZE),
      .READ_SIZE(READ_SIZE),
      .CLK_DIV  (CLK_DIV)
   ) dut (
      .I_clk   (clk),
      .I_reset (reset),
      .ctl     (bus),
      .I_sdi   (sdi),
      .O_sclk  (sclk),
      .O_csb   (csb),
      .O_sdo   (sdo),
      .O_sdo_oe(sdo_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int                   cyc = 0;
   logic                 prev_sclk = 1'b0;
   logic                 prev_csb = 1'b1;
   logic [DATA_SIZE-1:0] rx = '0;
   int                   rx_bits = 0;
   int                   rise_cnt = 0;
   int                   first_rise_cyc = 0;
   int                   busy_cnt = 0;
   int                   done_cnt = 0;
   int                   csb_low_cnt = 0;
   int                   oe_low_cnt = 0;
   int                   oe_low_rise = 0;
   int                   csb_high_run = 0;
   int                   last_gap = 0;
   logic [READ_SIZE-1:0] rdata_at_done = '0;
   logic [READ_SIZE-1:0] rd_pat = '0;
   logic [DATA_SIZE-1:0] words[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Samples the pins mid-cycle; also plays the converter, driving SDI only while SCLK is low.
   initial begin
      sdi = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (sclk && !prev_sclk) begin
            if (rx_bits == 0) first_rise_cyc = cyc;
            if (!sdo_oe) oe_low_rise++;
            rx = {rx[DATA_SIZE-2:0], sdo};
            rx_bits++;
            rise_cnt++;
         end
         if (bus.O_busy) busy_cnt++;
         if (!csb) csb_low_cnt++;
         if (!sdo_oe) oe_low_cnt++;
         if (csb) begin
            csb_high_run++;
         end else begin
            if (prev_csb) last_gap = csb_high_run;
            csb_high_run = 0;
         end
         if (bus.O_done) begin
            done_cnt++;
            rdata_at_done = bus.O_rdata;
            words.push_back(rx);
            rx      = '0;
            rx_bits = 0;
         end
         if (!sclk) begin
            if (rx_bits >= DATA_SIZE - READ_SIZE && rx_bits < DATA_SIZE)
               sdi = rd_pat[DATA_SIZE-1-rx_bits];
            else
               sdi = 1'b0;
         end
         prev_sclk = sclk;
         prev_csb  = csb;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear();
      rx          = '0;
      rx_bits     = 0;
      rise_cnt    = 0;
      busy_cnt    = 0;
      done_cnt    = 0;
      csb_low_cnt = 0;
      oe_low_cnt  = 0;
      oe_low_rise = 0;
      last_gap    = 0;
      words.delete();
   endtask

   task automatic start_txn(input logic [DATA_SIZE-1:0] data, output int s);
      bus.I_data  = data;
      bus.I_start = 1'b1;
      s           = cyc;
      tick();
      bus.I_start = 1'b0;
   endtask

   task automatic wait_done(input int n, input string tag);
      int k;
      k = 0;
      while (done_cnt < n && k < 400) begin
         tick();
         k++;
      end
      check(tag, 32'(done_cnt >= n), 32'd1);
   endtask

   task automatic wait_bits(input int n, input string tag);
      int k;
      k = 0;
      while (rx_bits < n && k < 400) begin
         tick();
         k++;
      end
      check(tag, 32'(rx_bits >= n), 32'd1);
   endtask

   function automatic logic [31:0] word_at(input int idx);
      if (idx < words.size()) return 32'(words[idx]);
      return 32'hDEAD_BEEF;
   endfunction

   initial begin
      int s;
      reset       = 1'b1;
      bus.I_start = 1'b0;
      bus.I_data  = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check("rst_busy",  32'(bus.O_busy),  32'd0);
      check("rst_done",  32'(bus.O_done),  32'd0);
      check("rst_sclk",  32'(sclk),        32'd0);
      check("rst_csb",   32'(csb),         32'd1);
      check("rst_sdo",   32'(sdo),         32'd0);
      check("rst_oe",    32'(sdo_oe),      32'd1);
      check("rst_rdata", 32'(bus.O_rdata), 32'd0);

      // plain write
      clear();
      start_txn(24'h000DA5, s);
      check("w_busy_t1", 32'(bus.O_busy), 32'd1);
      check("w_csb_t1",  32'(csb),        32'd0);
      check("w_sdo_t1",  32'(sdo),        32'd0);
      wait_done(1, "w_done_wait");
      repeat (3) tick();
      check("w_word",      word_at(0),              32'h000DA5);
      check("w_bits",      32'(rise_cnt),           32'd24);
      check("w_first_rise", 32'(first_rise_cyc - s), 32'd5);
      check("w_busy_len",  32'(busy_cnt),           32'd101);
      check("w_done_cnt",  32'(done_cnt),           32'd1);
      // CSB is low for every busy cycle except DONE
      check("w_csb_low",   32'(csb_low_cnt),        32'd100);
      check("w_oe_low",    32'(oe_low_cnt),         32'd0);
      $display("txn write data=0x000DA5 rx=0x%06h busy=%0d csb_low=%0d", word_at(0), busy_cnt, csb_low_cnt);

      // start while busy must be ignored
      clear();
      start_txn(24'h000DA5, s);
      wait_bits(5, "bz_bits_wait");
      bus.I_data  = 24'hFFFFFF;
      bus.I_start = 1'b1;
      tick();
      bus.I_start = 1'b0;
      wait_done(1, "bz_done_wait");
      repeat (10) tick();
      check("bz_word",     word_at(0),        32'h000DA5);
      check("bz_done_cnt", 32'(done_cnt),     32'd1);
      check("bz_idle",     32'(bus.O_busy),   32'd0);
      $display("txn busy-start data=0x000DA5 rx=0x%06h dones=%0d", word_at(0), done_cnt);

      // reset in the middle of a transfer
      clear();
      start_txn(24'h000DA5, s);
      wait_bits(10, "rs_bits_wait");
      reset = 1'b1;
      tick();
      check("rs_csb",  32'(csb),         32'd1);
      check("rs_sclk", 32'(sclk),        32'd0);
      check("rs_busy", 32'(bus.O_busy),  32'd0);
      check("rs_done", 32'(bus.O_done),  32'd0);
      reset = 1'b0;
      tick();
      check("rs_no_done", 32'(done_cnt), 32'd0);
      $display("txn aborted data=0x000DA5 bits_before_reset=%0d", rise_cnt);
      clear();
      start_txn(24'h00FF00, s);
      wait_done(1, "rs2_done_wait");
      repeat (3) tick();
      check("rs2_word",     word_at(0),    32'h00FF00);
      check("rs2_done_cnt", 32'(done_cnt), 32'd1);
      $display("txn after-reset data=0x00FF00 rx=0x%06h", word_at(0));

      // back-to-back with start held high
      clear();
      bus.I_data  = 24'h123456;
      bus.I_start = 1'b1;
      wait_done(1, "bb_done1_wait");
      bus.I_data = 24'h654321;
      wait_done(2, "bb_done2_wait");
      bus.I_start = 1'b0;
      repeat (3) tick();
      check("bb_count", 32'(words.size()), 32'd2);
      check("bb_word0", word_at(0),        32'h123456);
      check("bb_word1", word_at(1),        32'h654321);
      check("bb_gap",   32'(last_gap),     32'd2);
      $display("txn b2b rx0=0x%06h rx1=0x%06h csb_gap=%0d", word_at(0), word_at(1), last_gap);

      // read transaction, converter answers 0x5A
      clear();
      rd_pat = 8'h5A;
      start_txn(24'h800100, s);
      wait_done(1, "rd_done_wait");
      repeat (5) tick();
      check("rd_word",       word_at(0),         32'h800100);
      check("rd_oe_low",     32'(oe_low_cnt),    32'(EXP_OE_LOW));
      check("rd_oe_rise",    32'(oe_low_rise),   32'(EXP_OE_LOW_RISE));
      check("rd_rdata_done", 32'(rdata_at_done), 32'(EXP_RDATA));
      check("rd_rdata_hold", 32'(bus.O_rdata),   32'(EXP_RDATA));
      check("rd_oe_idle",    32'(sdo_oe),        32'd1);
      $display("txn read data=0x800100 rdata=0x%02h oe_low=%0d", bus.O_rdata, oe_low_cnt);

      // a write afterwards leaves read data untouched
      clear();
      rd_pat = 8'hC3;
      start_txn(24'h000DA5, s);
      wait_done(1, "wr2_done_wait");
      repeat (3) tick();
      check("wr2_rdata",  32'(bus.O_rdata), 32'(EXP_RDATA));
      check("wr2_oe_low", 32'(oe_low_cnt),  32'd0);
      $display("txn write-after-read data=0x000DA5 rdata=0x%02h", bus.O_rdata);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
